// File: rtl/byte_serializer.sv
// byte_serializer: captures a parallel byte on load and shifts it out
// MSB-first on serial_out, holding each bit for DIV clock cycles.
// Optional feature macro: BYTE_SERIALIZER_PARITY_EN appends an even-parity
// ninth bit after bit 0.
module byte_serializer #(
    parameter int unsigned DIV = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       load,
    input  logic [7:0] data_in,
    output logic       ready,
    output logic       serial_out,
    output logic       bit_valid,
    output logic       done
);

`ifdef BYTE_SERIALIZER_PARITY_EN
    localparam int unsigned NBITS = 9;
`else
    localparam int unsigned NBITS = 8;
`endif

    localparam logic [3:0]  LAST_BIT = 4'(NBITS - 1);
    localparam logic [15:0] DIV_M1   = 16'(DIV - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state_q, state_d;
    logic [NBITS-1:0]   shreg_q, shreg_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [15:0]        div_cnt_q, div_cnt_d;
    logic               ready_q, ready_d;
    logic               serial_q, serial_d;
    logic               bit_valid_q, bit_valid_d;
    logic               done_q, done_d;
    logic [NBITS-1:0]   frame_word;

`ifdef BYTE_SERIALIZER_PARITY_EN
    assign frame_word = {data_in, ^data_in};
`else
    assign frame_word = data_in;
`endif

    // Next-state, shift and counter logic; outputs are precomputed so they leave on flops.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        div_cnt_d   = div_cnt_q;
        bit_valid_d = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    shreg_d     = frame_word;
                    bit_cnt_d   = 4'd0;
                    div_cnt_d   = DIV_M1;
                    state_d     = SHIFT;
                    bit_valid_d = 1'b1;
                end
            end
            SHIFT: begin
                if (div_cnt_q == 16'd0) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d   = IDLE;
                        shreg_d   = '0;
                        bit_cnt_d = 4'd0;
                        done_d    = 1'b1;
                    end else begin
                        shreg_d     = {shreg_q[NBITS-2:0], 1'b0};
                        bit_cnt_d   = bit_cnt_q + 4'd1;
                        div_cnt_d   = DIV_M1;
                        bit_valid_d = 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d  = (state_d == IDLE);
        serial_d = (state_d == SHIFT) && shreg_d[NBITS-1];
    end

    // State, datapath and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= 4'd0;
            div_cnt_q   <= 16'd0;
            ready_q     <= 1'b1;
            serial_q    <= 1'b0;
            bit_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            div_cnt_q   <= div_cnt_d;
            ready_q     <= ready_d;
            serial_q    <= serial_d;
            bit_valid_q <= bit_valid_d;
            done_q      <= done_d;
        end
    end

    assign ready      = ready_q;
    assign serial_out = serial_q;
    assign bit_valid  = bit_valid_q;
    assign done       = done_q;

endmodule

// File: doc/byte_serializer.md
# byte_serializer

Downstream consumer of the 8-bit pipeline register. It captures the register's parallel byte on a load request and shifts it out MSB-first on a single serial line. Each bit is held for a programmable number of clock cycles. A ready/done handshake lets the upstream control logic pace successive bytes. It drives LED/GPIO-rate serial outputs from the register bank.

## Interface
- DIV, default 4: clock cycles each bit is held on serial_out; legal range 1..65535.
- clock  input  1  rising-edge system clock
- reset_n  input  1  asynchronous, active-low reset
- load  input  1  start request; sampled only while ready=1
- data_in  input  8  parallel byte (register Q output), captured when load accepted
- ready  output  1  high when idle and able to accept load
- serial_out  output  1  current serial bit; 0 when idle
- bit_valid  output  1  one-cycle strobe on the first cycle of each bit period
- done  output  1  one-cycle pulse when a frame completes

## Operation
- Reset values: ready=1, serial_out=0, bit_valid=0, done=0, state IDLE, shift register 0, counters 0.
- Two states: IDLE and SHIFT.
- IDLE:
  - ready=1, serial_out=0.
  - load=1 at a rising edge captures data_in into the shift register, sets bit_cnt=0 and div_cnt=DIV-1, and moves to SHIFT.
- SHIFT:
  - ready=0; serial_out = shift register MSB.
  - Each cycle, div_cnt decrements.
  - When div_cnt=0 and bit_cnt<7 (last bit index): shift left by one (0 in), bit_cnt+1, reload div_cnt=DIV-1.
  - When div_cnt=0 and bit_cnt=last: go to IDLE and assert done for the following cycle.
- bit_valid is high in the first cycle of every bit period, including the first bit.
- load while in SHIFT is ignored; there is no queueing and no error.
- data_in changes after capture have no effect on the frame in flight.
- div_cnt is 16 bits; bit_cnt is 4 bits. Neither counter wraps, because both reload on terminal count.
- Asserting reset_n low mid-frame:
  - Outputs return to reset values immediately (asynchronously).
  - The frame is aborted; done is not pulsed.

## Timing
- Load accepted at edge E0. Bit 7 appears on serial_out in the cycle after E0 (latency 1).
- Each bit is held exactly DIV cycles. An 8-bit frame occupies 8·DIV cycles.
- On the cycle after the last bit period: ready=1, done=1, serial_out=0.
- A load asserted in that same done cycle is accepted. Frames are therefore separated by exactly one idle cycle (minimum period 8·DIV+1).
- DIV=1: one bit per cycle; bit_valid is high in every SHIFT cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: BYTE_SERIALIZER_PARITY_EN.
- Defined:
  - A ninth bit, even parity (XOR of the captured byte), is sent after bit 0.
  - It is held DIV cycles with its own bit_valid strobe.
  - Frame length is 9·DIV cycles; the last bit index is 8.
- Undefined: 8-bit frames only; no parity logic is present.

## Test plan
- Reset, then DIV=4, load data_in=0xA5 → serial_out = 1,0,1,0,0,1,0,1, each held 4 cycles. bit_valid pulses 8 times, 4 cycles apart. done pulses at cycle 33 after the load edge with ready=1.
- Mid-frame, assert load with data_in=0xFF at cycle 10 → ignored; the frame stays 0xA5; ready remains 0 until the frame ends.
- Back-to-back: load 0x3C, then hold load=1 with data_in=0xC3 → the second frame starts in the done cycle. Exactly one idle cycle with serial_out=0 separates the frames.
- Reset asynchronously low at cycle 12 of a 0xF0 frame → serial_out=0 and ready=1 without waiting for a clock edge. No done pulse. The next load of 0x81 transmits correctly.
- DIV=1, load 0x81 → serial_out = 1,0,0,0,0,0,0,1 on consecutive cycles; done at cycle 9.
- With BYTE_SERIALIZER_PARITY_EN, DIV=2: 0xA5 → ninth bit 0; 0x07 → ninth bit 1. done at cycle 19 after load.
